// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : pipeline memory-access stage with req/ack data-memory port,
//             timeout abort, branch resolve and MEM/WB register.
// Optional:   MEM_MISALIGN_TRAP_EN traps accesses with addr[2:0] != 0.
// Revision:   1.0
// ============================================================================
module mem_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [63:0] pc_in,
  input  logic        zero_in,
  input  logic        branch_in,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic        memtoreg_in,
  input  logic        regwrite_in,
  input  logic [63:0] alu_result_in,
  input  logic [63:0] read_data2_in,
  input  logic [4:0]  write_reg_in,
  output logic        stall,
  output logic        pcsrc,
  output logic [63:0] branch_target,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        wb_valid,
  output logic [63:0] wb_read_data,
  output logic [63:0] wb_alu_result,
  output logic [4:0]  wb_write_reg,
  output logic        wb_memtoreg,
  output logic        wb_regwrite,
  output logic        bus_err,
  output logic        misalign
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic [63:0] wb_read_data_q, wb_read_data_d;
  logic [63:0] wb_alu_result_q, wb_alu_result_d;
  logic [4:0]  wb_write_reg_q, wb_write_reg_d;
  logic        wb_memtoreg_q, wb_memtoreg_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic        bus_err_q, bus_err_d;
  logic        misalign_q, misalign_d;

  logic memop;
  logic misaligned;
  logic issue;
  logic wait_more;

  assign memop = ex_valid & (memread_in | memwrite_in);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = memop & (alu_result_in[2:0] != 3'b000);
`else
  assign misaligned = 1'b0;
`endif

  assign issue     = (state_q == IDLE) & memop & ~misaligned;
  assign wait_more = (state_q == BUSY) & ~dmem_ack & (cnt_q != WAIT_LIMIT);

  assign stall         = issue | wait_more;
  assign pcsrc         = ex_valid & branch_in & zero_in & ~stall;
  assign branch_target = pc_in;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    req_d           = req_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    bus_err_d       = 1'b0;
    misalign_d      = 1'b0;
    // MEM/WB defaults to a bubble unless an instruction retires this cycle
    wb_valid_d      = 1'b0;
    wb_read_data_d  = 64'd0;
    wb_alu_result_d = 64'd0;
    wb_write_reg_d  = 5'd0;
    wb_memtoreg_d   = 1'b0;
    wb_regwrite_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = BUSY;
          cnt_d   = 8'd0;
          req_d   = 1'b1;
          we_d    = memwrite_in;
          addr_d  = alu_result_in;
          wdata_d = read_data2_in;
        end else if (misaligned) begin
          misalign_d      = 1'b1;
          wb_valid_d      = 1'b1;
          wb_alu_result_d = alu_result_in;
          wb_write_reg_d  = write_reg_in;
          wb_memtoreg_d   = memtoreg_in;
        end else if (ex_valid & ~memop) begin
          wb_valid_d      = 1'b1;
          wb_alu_result_d = alu_result_in;
          wb_write_reg_d  = write_reg_in;
          wb_memtoreg_d   = memtoreg_in;
          wb_regwrite_d   = regwrite_in;
        end
      end
      BUSY: begin
        // EX/MEM is held by stall, so its fields are still the access's own
        if (dmem_ack) begin
          state_d         = IDLE;
          req_d           = 1'b0;
          wb_valid_d      = 1'b1;
          wb_read_data_d  = we_q ? 64'd0 : dmem_rdata;
          wb_alu_result_d = alu_result_in;
          wb_write_reg_d  = write_reg_in;
          wb_memtoreg_d   = memtoreg_in;
          wb_regwrite_d   = regwrite_in;
        end else if (cnt_q == WAIT_LIMIT) begin
          state_d         = IDLE;
          req_d           = 1'b0;
          bus_err_d       = 1'b1;
          wb_valid_d      = 1'b1;
          wb_alu_result_d = alu_result_in;
          wb_write_reg_d  = write_reg_in;
          wb_memtoreg_d   = memtoreg_in;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= 8'd0;
      req_q           <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= 64'd0;
      wdata_q         <= 64'd0;
      wb_valid_q      <= 1'b0;
      wb_read_data_q  <= 64'd0;
      wb_alu_result_q <= 64'd0;
      wb_write_reg_q  <= 5'd0;
      wb_memtoreg_q   <= 1'b0;
      wb_regwrite_q   <= 1'b0;
      bus_err_q       <= 1'b0;
      misalign_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      req_q           <= req_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wb_valid_q      <= wb_valid_d;
      wb_read_data_q  <= wb_read_data_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_write_reg_q  <= wb_write_reg_d;
      wb_memtoreg_q   <= wb_memtoreg_d;
      wb_regwrite_q   <= wb_regwrite_d;
      bus_err_q       <= bus_err_d;
      misalign_q      <= misalign_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_write_reg  = wb_write_reg_q;
  assign wb_memtoreg   = wb_memtoreg_q;
  assign wb_regwrite   = wb_regwrite_q;
  assign bus_err       = bus_err_q;
  assign misalign      = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : directed stimulus with a MEM/WB scoreboard and monitor.
// Revision:     1.0
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, zero_in, branch_in, memread_in, memwrite_in;
  logic        memtoreg_in, regwrite_in, dmem_ack;
  logic [63:0] pc_in, alu_result_in, read_data2_in, dmem_rdata;
  logic [4:0]  write_reg_in;
  logic        stall, pcsrc, dmem_req, dmem_we, wb_valid, wb_memtoreg;
  logic        wb_regwrite, bus_err, misalign;
  logic [63:0] branch_target, dmem_addr, dmem_wdata, wb_read_data, wb_alu_result;
  logic [4:0]  wb_write_reg;

  typedef struct {
    logic [63:0] rd;
    logic [63:0] alu;
    logic [4:0]  wr;
    logic        m2r;
    logic        rw;
    logic        full;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_stage #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .pc_in(pc_in),
    .zero_in(zero_in), .branch_in(branch_in), .memread_in(memread_in),
    .memwrite_in(memwrite_in), .memtoreg_in(memtoreg_in),
    .regwrite_in(regwrite_in), .alu_result_in(alu_result_in),
    .read_data2_in(read_data2_in), .write_reg_in(write_reg_in),
    .stall(stall), .pcsrc(pcsrc), .branch_target(branch_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result), .wb_write_reg(wb_write_reg),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
    .bus_err(bus_err), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every retiring MEM/WB entry must match the head of the scoreboard
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wb_unexpected: got wb_valid=1 alu=%h expected no entry", wb_alu_result);
      end else begin
        e_mon = sb.pop_front();
        chk("wb_regwrite", {63'd0, wb_regwrite}, {63'd0, e_mon.rw});
        if (e_mon.full) begin
          chk("wb_read_data", wb_read_data, e_mon.rd);
          chk("wb_alu_result", wb_alu_result, e_mon.alu);
          chk("wb_write_reg", {59'd0, wb_write_reg}, {59'd0, e_mon.wr});
          chk("wb_memtoreg", {63'd0, wb_memtoreg}, {63'd0, e_mon.m2r});
        end
      end
    end else begin
      chk("bubble_regwrite", {63'd0, wb_regwrite}, 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 0; zero_in = 0; branch_in = 0; memread_in = 0; memwrite_in = 0;
    memtoreg_in = 0; regwrite_in = 0; dmem_ack = 0;
    pc_in = 0; alu_result_in = 0; read_data2_in = 0; dmem_rdata = 0; write_reg_in = 0;
  endtask

  // Memory access; ack_cyc < 0 means the memory never answers.
  task automatic do_mem(input logic is_store, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdata, input int ack_cyc, input logic rw,
                        input logic [4:0] rd, input int exp_stalls, input bit keep,
                        input logic exp_be, input logic exp_mis);
    int   n_st;
    bit   done;
    exp_t e;
    n_st = 0;
    done = 0;
    ex_valid = 1; branch_in = 0; zero_in = 0;
    memread_in = ~is_store; memwrite_in = is_store;
    memtoreg_in = ~is_store; regwrite_in = rw;
    alu_result_in = addr; read_data2_in = wdata; write_reg_in = rd;
    for (int c = 0; c < 40 && !done; c++) begin
      dmem_ack   = (c == ack_cyc);
      dmem_rdata = (c == ack_cyc) ? rdata : 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      if (c == 0) chk("req_setup", {63'd0, dmem_req}, 64'd0);
      if (c == 1) begin
        chk("req_high", {63'd0, dmem_req}, 64'd1);
        chk("dmem_we", {63'd0, dmem_we}, {63'd0, is_store});
        chk("dmem_addr", dmem_addr, addr);
        if (is_store) chk("dmem_wdata", dmem_wdata, wdata);
      end
      if (stall) n_st++;
      else begin
        done = 1;
        if (c == ack_cyc) begin
          e.rd = is_store ? 64'd0 : rdata; e.alu = addr; e.wr = rd;
          e.m2r = ~is_store; e.rw = rw; e.full = 1;
        end else begin
          e.rd = 0; e.alu = 0; e.wr = 0; e.m2r = 0; e.rw = 0; e.full = 0;
        end
        sb.push_back(e);
      end
      step();
    end
    dmem_ack = 0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL stall_release: got stall held 40 cycles expected release");
    end
    chk("stall_cycles", 64'(n_st), 64'(exp_stalls));
    if (!keep) begin
      clear_inputs();
      @(negedge clk);
      chk("wb_valid_latency", {63'd0, wb_valid}, 64'd1);
      chk("req_dropped", {63'd0, dmem_req}, 64'd0);
      chk("bus_err", {63'd0, bus_err}, {63'd0, exp_be});
      chk("misalign", {63'd0, misalign}, {63'd0, exp_mis});
      step();
    end
  endtask

  task automatic do_alu(input logic [63:0] alu, input logic [4:0] rd, input logic rw,
                        input logic br, input logic zero, input logic [63:0] pc,
                        input logic exp_pcsrc);
    exp_t e;
    ex_valid = 1; memread_in = 0; memwrite_in = 0; memtoreg_in = 0;
    regwrite_in = rw; alu_result_in = alu; write_reg_in = rd;
    branch_in = br; zero_in = zero; pc_in = pc;
    @(negedge clk);
    chk("alu_stall", {63'd0, stall}, 64'd0);
    chk("pcsrc", {63'd0, pcsrc}, {63'd0, exp_pcsrc});
    if (br) chk("branch_target", branch_target, pc);
    e.rd = 0; e.alu = alu; e.wr = rd; e.m2r = 0; e.rw = rw; e.full = 1;
    sb.push_back(e);
    step();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    step();
    step();
    @(negedge clk);
    chk("rst_req", {63'd0, dmem_req}, 64'd0);
    chk("rst_we", {63'd0, dmem_we}, 64'd0);
    chk("rst_addr", dmem_addr, 64'd0);
    chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_bus_err", {63'd0, bus_err}, 64'd0);
    chk("rst_misalign", {63'd0, misalign}, 64'd0);
    step();
    rst = 0;
    step();

    // Load 0x40, ack three cycles after the request cycle
    do_mem(1'b0, 64'h40, 64'h0, 64'hDEAD_BEEF, 4, 1'b1, 5'd5, 4, 0, 1'b0, 1'b0);
    // Store 0x1234 to 0x80, ack in the first request cycle
    do_mem(1'b1, 64'h80, 64'h1234, 64'h0, 1, 1'b0, 5'd0, 1, 0, 1'b0, 1'b0);

    // Non-memory ops and branches
    do_alu(64'h55, 5'd7, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    do_alu(64'h66, 5'd9, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    do_alu(64'h0, 5'd0, 1'b0, 1'b1, 1'b1, 64'h100, 1'b1);
    do_alu(64'h8, 5'd0, 1'b0, 1'b1, 1'b0, 64'h100, 1'b0);
    clear_inputs();
    step();

    // Timeout: stall through MAX_WAIT BUSY cycles, released on the aborting one
    do_mem(1'b0, 64'hC0, 64'h0, 64'h0, -1, 1'b1, 5'd3, 16, 0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bus_err_once", {63'd0, bus_err}, 64'd0);
    step();

    // Back-to-back loads: second one gets the usual one-cycle setup
    do_mem(1'b0, 64'h100, 64'h0, 64'h1111, 2, 1'b1, 5'd1, 2, 1, 1'b0, 1'b0);
    do_mem(1'b0, 64'h108, 64'h0, 64'h2222, 3, 1'b1, 5'd2, 3, 0, 1'b0, 1'b0);

    // Reset while BUSY, then a late ack
    ex_valid = 1; memread_in = 1; memtoreg_in = 1; regwrite_in = 1;
    alu_result_in = 64'h200; write_reg_in = 5'd4;
    step();
    step();
    @(negedge clk);
    chk("busy_req", {63'd0, dmem_req}, 64'd1);
    rst = 1;
    clear_inputs();
    step();
    rst = 0;
    dmem_ack = 1;
    dmem_rdata = 64'hFEED;
    @(negedge clk);
    chk("post_rst_req", {63'd0, dmem_req}, 64'd0);
    chk("post_rst_stall", {63'd0, stall}, 64'd0);
    step();
    dmem_ack = 0;
    @(negedge clk);
    chk("late_ack_req", {63'd0, dmem_req}, 64'd0);
    chk("late_ack_wb", {63'd0, wb_valid}, 64'd0);
    step();

`ifdef MEM_MISALIGN_TRAP_EN
    do_mem(1'b0, 64'h44, 64'h0, 64'h0, -1, 1'b1, 5'd6, 0, 0, 1'b0, 1'b1);
`else
    do_mem(1'b0, 64'h44, 64'h0, 64'h4444, 2, 1'b1, 5'd6, 2, 0, 1'b0, 1'b0);
`endif

    step();
    step();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
